// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the phase-1 ALU micro-sequencer: widths, opcodes,
// opcode classification helpers, state encoding and the output bundle.
package alu_defs;

    localparam int OPW   = 5;
    localparam int RSELW = 4;

    localparam logic [OPW-1:0] OP_ADD = 5'b00001;
    localparam logic [OPW-1:0] OP_SUB = 5'b00010;
    localparam logic [OPW-1:0] OP_AND = 5'b00011;
    localparam logic [OPW-1:0] OP_OR  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR = 5'b00101;
    localparam logic [OPW-1:0] OP_SHL = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL = 5'b01000;
    localparam logic [OPW-1:0] OP_NEG = 5'b01001;
    localparam logic [OPW-1:0] OP_NOT = 5'b01010;
    localparam logic [OPW-1:0] OP_MUL = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV = 5'b01111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RA   = 3'd1,
        ST_RB   = 3'd2,
        ST_WAIT = 3'd3,
        ST_ZLO  = 3'd4,
        ST_ZHI  = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } seq_state_e;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             err;
        logic             rout_en;
        logic [RSELW-1:0] rout_sel;
        logic             y_in;
        logic [OPW-1:0]   alu_op;
        logic             alu_start;
        logic             z_in;
        logic             zlo_out;
        logic             zhi_out;
        logic             rin_en;
        logic [RSELW-1:0] rin_sel;
        logic             lo_in;
        logic             hi_in;
    } seq_out_t;

    function automatic logic is_unary(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_multicycle(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_valid(input logic [OPW-1:0] op);
        logic v;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_MUL, OP_DIV: v = 1'b1;
            default:                                        v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_timeout_ctr.sv
// Wait-cycle counter for multi-cycle ALU ops; tc flags the wait cycle whose
// increment brings the count to MC_TIMEOUT-1, i.e. the last cycle worth waiting.
module alu_timeout_ctr #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    logic [CW-1:0] cnt_r;

    // Count wait cycles since the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = en && (cnt_r == CW'(MC_TIMEOUT - 2));

endmodule

// File: rtl/alu_op_sequencer.sv
// Micro-sequencer stepping the phase-1 ALU datapath through one operation per
// request; outputs are registered decodes of the next state.
module alu_op_sequencer
    import alu_defs::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [RSELW-1:0] ra,
    input  logic [RSELW-1:0] rb,
    input  logic [RSELW-1:0] rc,
    input  logic             alu_done,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rout_en,
    output logic [RSELW-1:0] rout_sel,
    output logic             y_in,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_start,
    output logic             z_in,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             rin_en,
    output logic [RSELW-1:0] rin_sel,
    output logic             lo_in,
    output logic             hi_in
);

    seq_state_e       state_r, state_nxt_s;
    logic [OPW-1:0]   op_r, op_nxt_s;
    logic [RSELW-1:0] ra_r, ra_nxt_s, rb_r, rb_nxt_s, rc_r, rc_nxt_s;
    seq_out_t         out_r, out_nxt_s;
    logic             tc_s;

    alu_timeout_ctr #(.MC_TIMEOUT(MC_TIMEOUT)) u_timeout (
        .clk   (clk),
        .rst_n (clr),
        .clear (state_r == ST_RB),
        .en    (state_r == ST_WAIT),
        .tc    (tc_s)
    );

    // Next-state and request capture.
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        ra_nxt_s    = ra_r;
        rb_nxt_s    = rb_r;
        rc_nxt_s    = rc_r;
        case (state_r)
            ST_IDLE: begin
                if (start && is_valid(opcode)) begin
                    op_nxt_s = opcode;
                    ra_nxt_s = ra;
                    rb_nxt_s = rb;
                    rc_nxt_s = rc;
                    if (is_unary(opcode)) begin
                        state_nxt_s = ST_RB;
                    end else begin
                        state_nxt_s = ST_RA;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RA: state_nxt_s = ST_RB;
            ST_RB: begin
                if (is_multicycle(op_r)) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ZLO;
                end
            end
            ST_WAIT: begin
                // A completion in the final wait cycle still wins over the timeout.
                if (alu_done) begin
                    state_nxt_s = ST_ZLO;
                end else if (tc_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ZLO: begin
                if (is_multicycle(op_r)) begin
                    state_nxt_s = ST_ZHI;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_ZHI:           state_nxt_s = ST_DONE;
            ST_DONE, ST_ERR:  state_nxt_s = ST_IDLE;
            default:          state_nxt_s = ST_IDLE;
        endcase
    end

    // Decode the outputs for the state about to be entered.
    always_comb begin
        out_nxt_s = '0;
        case (state_nxt_s)
            ST_IDLE: out_nxt_s.busy = 1'b0;
            ST_RA: begin
                out_nxt_s.busy     = 1'b1;
                out_nxt_s.rout_en  = 1'b1;
                out_nxt_s.rout_sel = ra_nxt_s;
                out_nxt_s.y_in     = 1'b1;
            end
            ST_RB: begin
                out_nxt_s.busy     = 1'b1;
                out_nxt_s.rout_en  = 1'b1;
                out_nxt_s.rout_sel = rb_nxt_s;
                out_nxt_s.alu_op   = op_nxt_s;
                if (is_multicycle(op_nxt_s)) begin
                    out_nxt_s.alu_start = 1'b1;
                end else begin
                    out_nxt_s.z_in = 1'b1;
                end
            end
            ST_WAIT: begin
                out_nxt_s.busy     = 1'b1;
                out_nxt_s.rout_en  = 1'b1;
                out_nxt_s.rout_sel = rb_nxt_s;
                out_nxt_s.alu_op   = op_nxt_s;
            end
            ST_ZLO: begin
                out_nxt_s.busy    = 1'b1;
                out_nxt_s.zlo_out = 1'b1;
                if (is_multicycle(op_nxt_s)) begin
                    out_nxt_s.lo_in = 1'b1;
                end else begin
                    out_nxt_s.rin_en  = 1'b1;
                    out_nxt_s.rin_sel = rc_nxt_s;
                end
            end
            ST_ZHI: begin
                out_nxt_s.busy    = 1'b1;
                out_nxt_s.zhi_out = 1'b1;
                out_nxt_s.hi_in   = 1'b1;
            end
            ST_DONE: begin
                out_nxt_s.busy = 1'b1;
                out_nxt_s.done = 1'b1;
            end
            ST_ERR: begin
                out_nxt_s.busy = 1'b1;
                out_nxt_s.done = 1'b1;
                out_nxt_s.err  = 1'b1;
            end
            default: out_nxt_s = '0;
        endcase
    end

    // State, captured request and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            op_r    <= '0;
            ra_r    <= '0;
            rb_r    <= '0;
            rc_r    <= '0;
            out_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            ra_r    <= ra_nxt_s;
            rb_r    <= rb_nxt_s;
            rc_r    <= rc_nxt_s;
            out_r   <= out_nxt_s;
        end
    end

    assign busy      = out_r.busy;
    assign done      = out_r.done;
    assign err       = out_r.err;
    assign rout_en   = out_r.rout_en;
    assign rout_sel  = out_r.rout_sel;
    assign y_in      = out_r.y_in;
    assign alu_op    = out_r.alu_op;
    assign alu_start = out_r.alu_start;
    // Z must latch in the same cycle the multi-cycle ALU reports completion.
    assign z_in      = out_r.z_in | ((state_r == ST_WAIT) & alu_done);
    assign zlo_out   = out_r.zlo_out;
    assign zhi_out   = out_r.zhi_out;
    assign rin_en    = out_r.rin_en;
    assign rin_sel   = out_r.rin_sel;
    assign lo_in     = out_r.lo_in;
    assign hi_in     = out_r.hi_in;

endmodule
